// File: rtl/oai32_sweep_pkg.sv
// Shared types, sweep constants and the golden OAI32 function for the arc-sweep sequencer.
package oai32_sweep_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StHold,
    StCheck,
    StFin
  } state_e;

  localparam int unsigned NUM_VEC       = 32;
  localparam int unsigned NUM_ARCS      = 23;
  localparam int unsigned STEPS_PER_ARC = 3;
  localparam int unsigned TOTAL_CHECKS  = NUM_VEC + NUM_ARCS * STEPS_PER_ARC;

  // vec is {A1,A2,A3,B1,B2}
  function automatic logic oai32_golden(input logic [4:0] vec);
    return ~((vec[4] | vec[3] | vec[2]) & (vec[1] | vec[0]));
  endfunction

endpackage

// File: rtl/oai32_arc_sweep_if.sv
// Bundles the sweeper's control/status signals and the cell-under-test pins.
interface oai32_arc_sweep_if #(
  parameter int unsigned ERRW = 8
);
  logic            START;
  logic            ZN;
  logic            A1, A2, A3, B1, B2;
  logic            BUSY;
  logic            DONE;
  logic            PASS;
  logic [ERRW-1:0] ERR_CNT;
  logic [4:0]      FAIL_VEC;
  logic [4:0]      ARC_IDX;

  modport master (
    input  START, ZN,
    output A1, A2, A3, B1, B2, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC, ARC_IDX
  );

  modport slave (
    output START, ZN,
    input  A1, A2, A3, B1, B2, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC, ARC_IDX
  );
endinterface

// File: rtl/oai32_arc_decode.sv
// Maps (arc index, step 0..2) to the {A1,A2,A3,B1,B2} drive vector for the arc phase.
module oai32_arc_decode
  import oai32_sweep_pkg::*;
(
  input  logic [4:0] arc_i,
  input  logic [1:0] step_i,
  output logic [4:0] vec_o
);

  logic       tog;
  logic [1:0] pin;
  logic [4:0] base;
  logic [4:0] rel;
  logic [2:0] a_fld;
  logic [1:0] b_fld;

  always_comb begin
    tog   = (step_i == 2'd1);
    pin   = 2'd0;
    base  = 5'd0;
    rel   = 5'd0;
    a_fld = 3'd0;
    b_fld = 2'd0;
    if (arc_i < 5'd9) begin
      // A-pin arcs: outer loop over pin, inner loop over B = 01,10,11
      if (arc_i < 5'd3) begin
        pin  = 2'd0;
        base = 5'd0;
      end else if (arc_i < 5'd6) begin
        pin  = 2'd1;
        base = 5'd3;
      end else begin
        pin  = 2'd2;
        base = 5'd6;
      end
      rel   = arc_i - base;
      b_fld = rel[1:0] + 2'd1;
      a_fld = tog ? (3'b100 >> pin) : 3'b000;
    end else begin
      rel = arc_i - 5'd9;
      if (rel < 5'd7) begin
        a_fld = 3'(rel + 5'd1);
        b_fld = tog ? 2'b10 : 2'b00;
      end else begin
        a_fld = 3'(rel - 5'd6);
        b_fld = tog ? 2'b01 : 2'b00;
      end
    end
    vec_o = {a_fld, b_fld};
  end

endmodule

// File: rtl/oai32_arc_sweep.sv
// Drives an OAI32 cell through an exhaustive sweep then a per-arc toggle sweep, checking ZN.
module oai32_arc_sweep
  import oai32_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERRW   = 8
) (
  input logic               CLK,
  input logic               RST,
  oai32_arc_sweep_if.master bus
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;
  logic [4:0]      idx_q, idx_d;
  logic [1:0]      sub_q, sub_d;
  logic [4:0]      vec_q, vec_d;
  logic [4:0]      arc_out_q, arc_out_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [ERRW-1:0] err_q, err_d;
  logic [4:0]      fvec_q, fvec_d;

  logic            ld_phase;
  logic [4:0]      ld_idx;
  logic [1:0]      ld_sub;
  logic            last_all;
  logic [4:0]      arc_vec;
  logic [4:0]      ld_vec;
  logic            mismatch;

  // Position of the next vector; outside CHECK this is the start of the sweep.
  always_comb begin
    ld_phase = 1'b0;
    ld_idx   = 5'd0;
    ld_sub   = 2'd0;
    last_all = 1'b0;
    if (state_q == StCheck) begin
      if (!phase_q) begin
        if (idx_q == 5'(NUM_VEC - 1)) begin
          ld_phase = 1'b1;
        end else begin
          ld_idx = idx_q + 5'd1;
        end
      end else begin
        ld_phase = 1'b1;
        if (sub_q == 2'(STEPS_PER_ARC - 1)) begin
          ld_idx   = idx_q + 5'd1;
          last_all = (idx_q == 5'(NUM_ARCS - 1));
        end else begin
          ld_idx = idx_q;
          ld_sub = sub_q + 2'd1;
        end
      end
    end
  end

  oai32_arc_decode u_arc_decode (
    .arc_i  (ld_idx),
    .step_i (ld_sub),
    .vec_o  (arc_vec)
  );

  assign ld_vec   = ld_phase ? arc_vec : ld_idx;
  // X/Z on ZN must count as a failure, hence the case inequality.
  assign mismatch = (bus.ZN !== oai32_golden(vec_q));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    sub_d     = sub_q;
    vec_d     = vec_q;
    arc_out_d = arc_out_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    fvec_d    = fvec_q;
    unique case (state_q)
      StIdle, StFin: begin
        if (bus.START) begin
          err_d     = '0;
          fvec_d    = 5'd0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
          phase_d   = ld_phase;
          idx_d     = ld_idx;
          sub_d     = ld_sub;
          vec_d     = ld_vec;
          arc_out_d = 5'd0;
          state_d   = StApply;
        end
      end
      StApply: begin
        if (SETTLE <= 1) begin
          state_d = StCheck;
        end else begin
          cnt_d   = CntW'(1);
          state_d = StHold;
        end
      end
      StHold: begin
        if (cnt_q == CntW'(SETTLE - 1)) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCheck: begin
        if (mismatch) begin
          if (err_q == '0) begin
            fvec_d = vec_q;
          end
          if (err_q != {ERRW{1'b1}}) begin
            err_d = err_q + ERRW'(1);
          end
        end
        if (last_all) begin
          vec_d     = 5'd0;
          arc_out_d = 5'd0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = StFin;
        end else begin
          phase_d   = ld_phase;
          idx_d     = ld_idx;
          sub_d     = ld_sub;
          vec_d     = ld_vec;
          arc_out_d = ld_phase ? ld_idx : 5'd0;
          state_d   = StApply;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      idx_q     <= 5'd0;
      sub_q     <= 2'd0;
      vec_q     <= 5'd0;
      arc_out_q <= 5'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= '0;
      fvec_q    <= 5'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      sub_q     <= sub_d;
      vec_q     <= vec_d;
      arc_out_q <= arc_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      fvec_q    <= fvec_d;
    end
  end

  assign {bus.A1, bus.A2, bus.A3, bus.B1, bus.B2} = vec_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.PASS     = done_q & (err_q == '0);
  assign bus.ERR_CNT  = err_q;
  assign bus.FAIL_VEC = fvec_q;
  assign bus.ARC_IDX  = arc_out_q;

endmodule

// File: doc/oai32_arc_sweep.md
# oai32_arc_sweep

Self-checking stimulus/response sequencer that sits directly upstream and downstream of an OAI32 cell instance (ZN = ~((A1|A2|A3)&(B1|B2))). It drives the cell's five inputs with an exhaustive truth-table sweep, then with a toggle sweep over every conditional timing arc. It samples ZN, compares it against the golden function, and reports pass/fail, an error count and the first failing vector. It is used in cell-level regression and silicon-correlation benches.

## Interface
- SETTLE, default 2: cycles a vector is held before ZN is sampled (≥1).
- ERRW, default 8: width of the error counter.
- CLK  in  1: clock, rising edge.
- RST  in  1: asynchronous, active-high reset.
- START  in  1: one-cycle pulse that begins a sweep; ignored while BUSY.
- ZN  in  1: output of the cell under test.
- A1, A2, A3, B1, B2  out  1 each: registered drive to the cell under test.
- BUSY  out  1: sweep in progress.
- DONE  out  1: sweep finished; held until the next START or reset.
- PASS  out  1: DONE & (ERR_CNT==0).
- ERR_CNT  out  ERRW: saturating mismatch count.
- FAIL_VEC  out  5: {A1,A2,A3,B1,B2} of the first mismatch.
- ARC_IDX  out  5: current arc index (0–22) in the arc phase, else 0.

## Operation
- Reset value of every output is 0; the FSM resets to IDLE.
- FSM states: IDLE → APPLY → HOLD → CHECK → (APPLY | FIN) → IDLE-equivalent DONE.
  - START in IDLE or DONE clears ERR_CNT, FAIL_VEC and DONE, then enters APPLY.
- Phase EXH: 32 vectors, {A1,A2,A3,B1,B2} = idx[4:0], idx 0..31 ascending.
- Phase ARC: 23 arcs. Each arc applies three vectors: toggled pin = 0, 1, 0.
  - Arcs 0–8: pin A1, A2, A3 (outer loop). B={B1,B2} = 01, 10, 11 (inner loop). The other A pins are 0.
  - Arcs 9–22: pin B1, then B2. {A1,A2,A3} = 001..111 ascending. The other B pin is 0.
- Each step: APPLY registers the vector onto the outputs. HOLD counts SETTLE−1 cycles. CHECK compares ZN with the golden value.
- Mismatch handling:
  - A mismatch is ZN !== golden; X and Z count as mismatch.
  - ERR_CNT increments and saturates at 2^ERRW−1.
  - FAIL_VEC is captured only on the first mismatch.
- After the 101st check the FSM enters FIN: outputs return to all 0, BUSY drops and DONE rises.
- RST asserted mid-sweep forces all outputs and state to their reset values immediately, with no clock required.

## Timing
- Vector k is driven from the rising edge at cycle t. ZN is sampled at the edge ending cycle t+SETTLE.
- Each vector occupies exactly SETTLE+1 cycles.
- START sampled at cycle 0 → BUSY=1 from cycle 1, first vector driven at cycle 1.
- DONE=1 at cycle 1+101·(SETTLE+1); 304 cycles with SETTLE=2.
- START coincident with the final CHECK is ignored.
- START coincident with RST is ignored.
- ZN is treated as combinational from A*/B*. The block adds no synchronizer.

## Structure
- Package oai32_sweep_pkg holds:
  - the state enum;
  - constants NUM_VEC=32, NUM_ARCS=23, STEPS_PER_ARC=3, TOTAL_CHECKS=101;
  - function oai32_golden(vec) returning the expected ZN.
- One sub-module, oai32_arc_decode: combinational map (arc index, step 0–2) → 5-bit vector, per the ordering above.
- The top level contains the FSM, the settle counter, the index counters and the result registers.

## Test plan
- Correct behavioural OAI32 connected, SETTLE=2, START pulse → DONE at cycle 304, PASS=1, ERR_CNT=0, FAIL_VEC=0.
- ZN stuck at 1 → ERR_CNT=44 (21 EXH + 23 ARC), FAIL_VEC=5'b00101, PASS=0.
- ZN stuck at 0, ERRW=4 → ERR_CNT saturates at 15 (true count 57), FAIL_VEC=5'b00000.
- RST asserted during arc 12 → all outputs 0 in the same cycle. A new START yields a full clean sweep with PASS=1.
- START pulsed every cycle during BUSY → completion time unchanged (304 cycles). A START after DONE clears DONE and ERR_CNT.
- Arc ordering check: with a correct DUT, log A*/B* at each CHECK in the ARC phase.
  - Arc 0 gives 00001, 10001, 00001.
  - Arc 22 gives 11100, 11101, 11100.
